// File: rtl/mem_access.sv
// MEM stage: runs EX_MEM loads/stores on the AHB-Lite data port and registers MEM_WB.
// Optional macro MEM_ACCESS_MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them.
module mem_access #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] EX_MEM_pc,
    input  logic [31:0] EX_MEM_inst,
    input  logic [31:0] EX_MEM_alu,
    input  logic [31:0] EX_MEM_rs2,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        EX_MEM_is_load,
    input  logic        EX_MEM_is_store,
    input  logic        EX_MEM_is_jal,
    input  logic        EX_MEM_is_jalr,
    output logic [31:0] HADDR_D,
    output logic [1:0]  HTRANS_D,
    output logic        HWRITE_D,
    output logic [2:0]  HSIZE_D,
    output logic [31:0] HWDATA_D,
    input  logic [31:0] HRDATA_D,
    input  logic        HREADY_D,
    input  logic        HRESP_D,
    output logic        mem_stall,
    output logic        bus_err,
    output logic [31:0] MEM_WB_pc,
    output logic [31:0] MEM_WB_inst,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_we,
    output logic [31:0] MEM_WB_wdata,
    output logic        misalign_exc,
    output logic [31:0] misalign_addr
);
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR} state_t;
    state_t state, state_nxt;

    function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                                 input logic [1:0] lo,
                                                 input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[8*lo +: 8];
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b100:  load_extract = {24'd0, b};
            3'b101:  load_extract = {16'd0, h};
            default: load_extract = rdata;
        endcase
    endfunction

    function automatic logic wb_enable(input logic [31:0] inst, input logic [4:0] rd,
                                       input logic store);
        wb_enable = (rd != 5'd0) && !store && (inst[6:0] != 7'b1100011) && (inst != 32'd0);
    endfunction

    // Address-phase decode, straight off EX_MEM
    logic [2:0]  funct3_p0;
    logic        mem_op_p0, misalign_p0, trap_p0, start_p0;
    logic [31:0] haddr_p0, lane_p0;

    assign funct3_p0   = EX_MEM_inst[14:12];
    assign mem_op_p0   = EX_MEM_is_load | EX_MEM_is_store;
    assign misalign_p0 = ((funct3_p0[1:0] == 2'b01) && EX_MEM_alu[0]) ||
                         ((funct3_p0[1:0] == 2'b10) && (EX_MEM_alu[1:0] != 2'b00));
    assign haddr_p0    = (funct3_p0[1:0] == 2'b01) ? {EX_MEM_alu[31:1], 1'b0} :
                         (funct3_p0[1:0] == 2'b10) ? {EX_MEM_alu[31:2], 2'b00} : EX_MEM_alu;
    assign lane_p0     = (funct3_p0[1:0] == 2'b00) ? {4{EX_MEM_rs2[7:0]}} :
                         (funct3_p0[1:0] == 2'b01) ? {2{EX_MEM_rs2[15:0]}} : EX_MEM_rs2;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign trap_p0       = mem_op_p0 & misalign_p0;
    assign misalign_exc  = trap_p0 && (state == S_IDLE) && !RES;
    assign misalign_addr = misalign_exc ? EX_MEM_alu : 32'd0;
`else
    assign trap_p0       = 1'b0;
    assign misalign_exc  = 1'b0;
    assign misalign_addr = 32'd0;
`endif

    assign start_p0 = (state == S_IDLE) && mem_op_p0 && !trap_p0 && !RES;

    // Data-phase context captured at the address phase
    logic [1:0]  addr_lo_p1;
    logic [2:0]  funct3_p1;
    logic [4:0]  rd_p1;
    logic [31:0] inst_p1, pc_p1, alu_p1, lane_p1;
    logic        is_load_p1, is_store_p1;

    always_ff @(posedge CLK) begin
        if (start_p0) begin
            addr_lo_p1  <= EX_MEM_alu[1:0];
            funct3_p1   <= funct3_p0;
            rd_p1       <= EX_MEM_rd;
            inst_p1     <= EX_MEM_inst;
            pc_p1       <= EX_MEM_pc;
            alu_p1      <= EX_MEM_alu;
            lane_p1     <= lane_p0;
            is_load_p1  <= EX_MEM_is_load;
            is_store_p1 <= EX_MEM_is_store;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        HADDR_D   = 32'd0;
        HTRANS_D  = 2'b00;
        HWRITE_D  = 1'b0;
        HSIZE_D   = 3'd0;
        HWDATA_D  = 32'd0;
        mem_stall = 1'b0;
        bus_err   = 1'b0;
        if (!RES) begin
            case (state)
                S_IDLE: if (start_p0) begin
                    HTRANS_D  = 2'b10;
                    HADDR_D   = haddr_p0;
                    HWRITE_D  = EX_MEM_is_store;
                    HSIZE_D   = {1'b0, funct3_p0[1:0]};
                    mem_stall = 1'b1;
                    state_nxt = S_DATA;
                end
                S_DATA: begin
                    HWDATA_D = lane_p1;
                    if (HRESP_D) begin
                        mem_stall = 1'b1;
                        state_nxt = S_ERR;
                    end else if (HREADY_D) begin
                        state_nxt = S_IDLE;
                    end else begin
                        mem_stall = 1'b1;
                    end
                end
                S_ERR: begin
                    bus_err   = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // MEM_WB register: bubble while stalled, else the finished access or pass-through
    always_ff @(posedge CLK) begin
        if (RES) begin
            MEM_WB_pc    <= RESET_PC;
            MEM_WB_inst  <= 32'd0;
            MEM_WB_rd    <= 5'd0;
            MEM_WB_we    <= 1'b0;
            MEM_WB_wdata <= 32'd0;
        end else if (mem_stall) begin
            MEM_WB_inst  <= 32'd0;
            MEM_WB_rd    <= 5'd0;
            MEM_WB_we    <= 1'b0;
            MEM_WB_wdata <= 32'd0;
        end else if (state == S_IDLE) begin
            MEM_WB_pc    <= EX_MEM_pc;
            MEM_WB_inst  <= EX_MEM_inst;
            MEM_WB_rd    <= EX_MEM_rd;
            MEM_WB_we    <= wb_enable(EX_MEM_inst, EX_MEM_rd, EX_MEM_is_store) & !trap_p0;
            MEM_WB_wdata <= (EX_MEM_is_jal | EX_MEM_is_jalr) ? EX_MEM_pc + 32'd4 : EX_MEM_alu;
        end else begin
            MEM_WB_pc    <= pc_p1;
            MEM_WB_inst  <= inst_p1;
            MEM_WB_rd    <= rd_p1;
            MEM_WB_we    <= wb_enable(inst_p1, rd_p1, is_store_p1) & (state == S_DATA);
            MEM_WB_wdata <= is_load_p1 ? load_extract(HRDATA_D, addr_lo_p1, funct3_p1) : alu_p1;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; honours MEM_ACCESS_MISALIGN_TRAP_EN.
module tb_mem_access;
    logic        CLK = 1'b0;
    logic        RES;
    logic [31:0] EX_MEM_pc, EX_MEM_inst, EX_MEM_alu, EX_MEM_rs2;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_is_load, EX_MEM_is_store, EX_MEM_is_jal, EX_MEM_is_jalr;
    logic [31:0] HADDR_D, HWDATA_D, HRDATA_D;
    logic [1:0]  HTRANS_D;
    logic        HWRITE_D, HREADY_D, HRESP_D;
    logic [2:0]  HSIZE_D;
    logic        mem_stall, bus_err, MEM_WB_we, misalign_exc;
    logic [31:0] MEM_WB_pc, MEM_WB_inst, MEM_WB_wdata, misalign_addr;
    logic [4:0]  MEM_WB_rd;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] I_LW  = 32'h0000_2283;
    localparam logic [31:0] I_LB  = 32'h0000_0303;
    localparam logic [31:0] I_LBU = 32'h0000_4303;
    localparam logic [31:0] I_SH  = 32'h0000_1023;
    localparam logic [31:0] I_JAL = 32'h0000_00EF;
    localparam logic [31:0] I_BEQ = 32'h0000_0063;
    localparam logic [31:0] I_ADD = 32'h0000_03B3;

    always #5 CLK = ~CLK;

    mem_access #(.RESET_PC(32'h8000_0000)) dut (
        .CLK(CLK), .RES(RES),
        .EX_MEM_pc(EX_MEM_pc), .EX_MEM_inst(EX_MEM_inst), .EX_MEM_alu(EX_MEM_alu),
        .EX_MEM_rs2(EX_MEM_rs2), .EX_MEM_rd(EX_MEM_rd),
        .EX_MEM_is_load(EX_MEM_is_load), .EX_MEM_is_store(EX_MEM_is_store),
        .EX_MEM_is_jal(EX_MEM_is_jal), .EX_MEM_is_jalr(EX_MEM_is_jalr),
        .HADDR_D(HADDR_D), .HTRANS_D(HTRANS_D), .HWRITE_D(HWRITE_D), .HSIZE_D(HSIZE_D),
        .HWDATA_D(HWDATA_D), .HRDATA_D(HRDATA_D), .HREADY_D(HREADY_D), .HRESP_D(HRESP_D),
        .mem_stall(mem_stall), .bus_err(bus_err),
        .MEM_WB_pc(MEM_WB_pc), .MEM_WB_inst(MEM_WB_inst), .MEM_WB_rd(MEM_WB_rd),
        .MEM_WB_we(MEM_WB_we), .MEM_WB_wdata(MEM_WB_wdata),
        .misalign_exc(misalign_exc), .misalign_addr(misalign_addr)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic ld,
                         input logic st, input logic jal);
        EX_MEM_pc = pc; EX_MEM_inst = inst; EX_MEM_alu = alu; EX_MEM_rs2 = rs2;
        EX_MEM_rd = rd; EX_MEM_is_load = ld; EX_MEM_is_store = st;
        EX_MEM_is_jal = jal; EX_MEM_is_jalr = 1'b0;
        #1;
    endtask

    task automatic bubble();
        drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        RES = 1'b1; HREADY_D = 1'b1; HRESP_D = 1'b0; HRDATA_D = 32'd0;
        bubble();
        tick(); tick();
        RES = 1'b0;
        #1;
        n_vec++; if (MEM_WB_pc !== 32'h8000_0000) begin n_err++; $display("FAIL reset_pc got %h want 80000000", MEM_WB_pc); end
        n_vec++; if ({MEM_WB_inst, MEM_WB_rd, MEM_WB_we, MEM_WB_wdata} !== 70'd0) begin n_err++; $display("FAIL reset_wb got %h/%0d/%b/%h want zeros", MEM_WB_inst, MEM_WB_rd, MEM_WB_we, MEM_WB_wdata); end
        n_vec++; if ({HTRANS_D, mem_stall, bus_err, misalign_exc} !== 5'd0) begin n_err++; $display("FAIL reset_ctl got htrans=%0d stall=%b err=%b mis=%b want 0", HTRANS_D, mem_stall, bus_err, misalign_exc); end
    endtask

    task automatic test_lw();
        HREADY_D = 1'b1; HRDATA_D = 32'hDEAD_BEEF;
        drive(32'h8000_0000, I_LW, 32'h100, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        n_vec++; if (HTRANS_D !== 2'b10 || HADDR_D !== 32'h100 || HWRITE_D !== 1'b0 || HSIZE_D !== 3'd2) begin n_err++; $display("FAIL lw_addr got %0d/%h/%b/%0d want 2/100/0/2", HTRANS_D, HADDR_D, HWRITE_D, HSIZE_D); end
        n_vec++; if (mem_stall !== 1'b1) begin n_err++; $display("FAIL lw_stall_a got %b want 1", mem_stall); end
        tick(); bubble();
        n_vec++; if (mem_stall !== 1'b0 || HTRANS_D !== 2'b00) begin n_err++; $display("FAIL lw_data got stall=%b htrans=%0d want 0/0", mem_stall, HTRANS_D); end
        n_vec++; if (MEM_WB_inst !== 32'd0 || MEM_WB_we !== 1'b0) begin n_err++; $display("FAIL lw_bubble got %h/%b want 0/0", MEM_WB_inst, MEM_WB_we); end
        tick();
        n_vec++; if (MEM_WB_we !== 1'b1 || MEM_WB_rd !== 5'd5 || MEM_WB_wdata !== 32'hDEAD_BEEF || MEM_WB_inst !== I_LW) begin n_err++; $display("FAIL lw_wb got we=%b rd=%0d wd=%h inst=%h want 1/5/deadbeef/%h", MEM_WB_we, MEM_WB_rd, MEM_WB_wdata, MEM_WB_inst, I_LW); end
    endtask

    task automatic test_byte_loads();
        logic [31:0] insts [2];
        logic [31:0] exp [2];
        insts[0] = I_LB; insts[1] = I_LBU; exp[0] = 32'hFFFF_FF80; exp[1] = 32'h0000_0080;
        HREADY_D = 1'b1; HRDATA_D = 32'h8012_3456;
        for (int i = 0; i < 2; i++) begin
            drive(32'h8000_0004, insts[i], 32'h103, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0);
            n_vec++; if (HADDR_D !== 32'h103 || HSIZE_D !== 3'd0) begin n_err++; $display("FAIL byte_addr[%0d] got %h/%0d want 103/0", i, HADDR_D, HSIZE_D); end
            tick(); bubble(); tick();
            n_vec++; if (MEM_WB_wdata !== exp[i] || MEM_WB_we !== 1'b1) begin n_err++; $display("FAIL byte_wb[%0d] got %h/%b want %h/1", i, MEM_WB_wdata, MEM_WB_we, exp[i]); end
        end
    endtask

    task automatic test_sh_wait();
        int stalls = 0;
        HREADY_D = 1'b1;
        drive(32'h8000_0008, I_SH, 32'h102, 32'h0000_1234, 5'd3, 1'b0, 1'b1, 1'b0);
        n_vec++; if (HSIZE_D !== 3'd1 || HWRITE_D !== 1'b1 || HADDR_D !== 32'h102) begin n_err++; $display("FAIL sh_addr got size=%0d wr=%b addr=%h want 1/1/102", HSIZE_D, HWRITE_D, HADDR_D); end
        if (mem_stall === 1'b1) stalls++;
        tick(); bubble(); HREADY_D = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (HWDATA_D !== 32'h1234_1234 || HTRANS_D !== 2'b00) begin n_err++; $display("FAIL sh_wdata[%0d] got %h/%0d want 12341234/0", i, HWDATA_D, HTRANS_D); end
            if (mem_stall === 1'b1) stalls++;
            tick();
        end
        HREADY_D = 1'b1; #1;
        if (mem_stall === 1'b1) stalls++;
        n_vec++; if (stalls !== 4) begin n_err++; $display("FAIL sh_stall_cycles got %0d want 4", stalls); end
        tick();
        n_vec++; if (MEM_WB_we !== 1'b0 || MEM_WB_inst !== I_SH) begin n_err++; $display("FAIL sh_wb got we=%b inst=%h want 0/%h", MEM_WB_we, MEM_WB_inst, I_SH); end
    endtask

    task automatic test_bus_error();
        HREADY_D = 1'b1; HRESP_D = 1'b0;
        drive(32'h8000_000C, I_LW, 32'h200, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        tick(); bubble();
        HREADY_D = 1'b0; HRESP_D = 1'b1; #1;
        n_vec++; if (bus_err !== 1'b0 || mem_stall !== 1'b1) begin n_err++; $display("FAIL err_c1 got err=%b stall=%b want 0/1", bus_err, mem_stall); end
        tick();
        HREADY_D = 1'b1; #1;
        n_vec++; if (bus_err !== 1'b1 || mem_stall !== 1'b0) begin n_err++; $display("FAIL err_c2 got err=%b stall=%b want 1/0", bus_err, mem_stall); end
        tick();
        HRESP_D = 1'b0; #1;
        n_vec++; if (MEM_WB_we !== 1'b0 || MEM_WB_inst !== I_LW || bus_err !== 1'b0) begin n_err++; $display("FAIL err_wb got we=%b inst=%h err=%b want 0/%h/0", MEM_WB_we, MEM_WB_inst, bus_err, I_LW); end
        drive(32'h8000_0010, I_LW, 32'h300, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        n_vec++; if (HTRANS_D !== 2'b10) begin n_err++; $display("FAIL err_idle got htrans=%0d want 2", HTRANS_D); end
        tick(); bubble(); tick();
    endtask

    task automatic test_reset_mid();
        HREADY_D = 1'b1;
        drive(32'h8000_0020, I_LW, 32'h400, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0);
        tick(); bubble(); HREADY_D = 1'b0;
        RES = 1'b1;
        tick();
        RES = 1'b0; #1;
        n_vec++; if (HTRANS_D !== 2'b00 || mem_stall !== 1'b0 || MEM_WB_inst !== 32'd0 || MEM_WB_pc !== 32'h8000_0000) begin n_err++; $display("FAIL rst_mid got htrans=%0d stall=%b inst=%h pc=%h want 0/0/0/80000000", HTRANS_D, mem_stall, MEM_WB_inst, MEM_WB_pc); end
        HREADY_D = 1'b1;
    endtask

    task automatic test_non_mem();
        drive(32'h8000_0010, I_JAL, 32'h1234, 32'd0, 5'd1, 1'b0, 1'b0, 1'b1);
        n_vec++; if (mem_stall !== 1'b0 || HTRANS_D !== 2'b00) begin n_err++; $display("FAIL jal_ctl got stall=%b htrans=%0d want 0/0", mem_stall, HTRANS_D); end
        tick();
        n_vec++; if (MEM_WB_wdata !== 32'h8000_0014 || MEM_WB_we !== 1'b1 || MEM_WB_rd !== 5'd1) begin n_err++; $display("FAIL jal_wb got %h/%b/%0d want 80000014/1/1", MEM_WB_wdata, MEM_WB_we, MEM_WB_rd); end
        drive(32'h8000_0014, I_BEQ, 32'h1, 32'd0, 5'd7, 1'b0, 1'b0, 1'b0);
        tick();
        n_vec++; if (MEM_WB_we !== 1'b0 || MEM_WB_inst !== I_BEQ) begin n_err++; $display("FAIL beq_wb got we=%b inst=%h want 0/%h", MEM_WB_we, MEM_WB_inst, I_BEQ); end
        drive(32'h8000_0018, I_ADD, 32'h55, 32'd0, 5'd7, 1'b0, 1'b0, 1'b0);
        tick();
        n_vec++; if (MEM_WB_wdata !== 32'h55 || MEM_WB_we !== 1'b1 || MEM_WB_pc !== 32'h8000_0018) begin n_err++; $display("FAIL add_wb got %h/%b/%h want 55/1/80000018", MEM_WB_wdata, MEM_WB_we, MEM_WB_pc); end
        drive(32'h8000_001C, I_ADD, 32'h66, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        n_vec++; if (MEM_WB_we !== 1'b0 || MEM_WB_wdata !== 32'h66) begin n_err++; $display("FAIL add_x0 got we=%b wd=%h want 0/66", MEM_WB_we, MEM_WB_wdata); end
    endtask

    task automatic test_misalign();
        HREADY_D = 1'b1; HRDATA_D = 32'hCAFE_F00D;
        drive(32'h8000_0030, I_LW, 32'h101, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        n_vec++; if (misalign_exc !== 1'b1 || misalign_addr !== 32'h101 || HTRANS_D !== 2'b00 || mem_stall !== 1'b0) begin n_err++; $display("FAIL mis_trap got exc=%b addr=%h htrans=%0d stall=%b want 1/101/0/0", misalign_exc, misalign_addr, HTRANS_D, mem_stall); end
        tick(); bubble();
        n_vec++; if (MEM_WB_we !== 1'b0 || misalign_exc !== 1'b0) begin n_err++; $display("FAIL mis_wb got we=%b exc=%b want 0/0", MEM_WB_we, misalign_exc); end
`else
        n_vec++; if (HTRANS_D !== 2'b10 || HADDR_D !== 32'h100 || misalign_exc !== 1'b0 || misalign_addr !== 32'd0) begin n_err++; $display("FAIL mis_align got htrans=%0d addr=%h exc=%b maddr=%h want 2/100/0/0", HTRANS_D, HADDR_D, misalign_exc, misalign_addr); end
        tick(); bubble(); tick();
        n_vec++; if (MEM_WB_we !== 1'b1 || MEM_WB_wdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL mis_wb got we=%b wd=%h want 1/cafef00d", MEM_WB_we, MEM_WB_wdata); end
`endif
    endtask

    initial begin
        test_reset();
        test_lw();
        test_byte_loads();
        test_sh_wait();
        test_bus_error();
        test_reset_mid();
        test_non_mem();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
